// File: rtl/aes_pkg.sv
// Shared AES tables and helpers used by both the encryption and decryption datapaths.
// Byte 0 of a block sits in bits [127:120]; the state is column-major.
package aes_pkg;

   localparam int AES_NUM_ROUNDS = 10;

   typedef logic [127:0] aes_block_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } aes_state_e;

   // Entry n occupies bits [2047-8n -: 8].
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[2047 - 8 * int'(b) -: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[2047 - 8 * int'(b) -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      if (r >= 4'd1 && r <= 4'd10) return RCON[r];
      return 8'h00;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // One step of the AES-128 key schedule: previous round key in, next round key out.
   function automatic aes_block_t key_expand(input aes_block_t key, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = key[127:96] ^ sub_word({key[23:0], key[31:24]}) ^ {rc, 24'h000000};
      w1 = key[95:64] ^ w0;
      w2 = key[63:32] ^ w1;
      w3 = key[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_encryption_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (bypassed on the final round) and AddRoundKey.
module aes_encryption_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] round_key,
   input  logic         final_round,
   output logic [127:0] next_state
);

   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];

   always_comb begin
      next_state = '0;
      for (int i = 0; i < 16; i++) begin
         sb[i] = sbox(state[127 - 8*i -: 8]);
      end
      // Row r of column c takes the byte from column c+r of the same row.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[4*c + r] = sb[4*((c + r) % 4) + r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[4*c + 0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
      for (int i = 0; i < 16; i++) begin
         next_state[127 - 8*i -: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[127 - 8*i -: 8];
      end
   end

endmodule

// File: rtl/aes_encryption_core.sv
// Iterative AES-128 encryption core: initial AddRoundKey on accept, then one round
// per clock with the round key expanded on the fly, result held until taken.
module aes_encryption_core
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = 10
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [127:0] IN_DATA,
   input  logic [127:0] IN_KEY,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [127:0] OUT_DATA
);

   if (NUM_ROUNDS != AES_NUM_ROUNDS) begin : g_bad_rounds
      $error("aes_encryption_core: NUM_ROUNDS must be 10 for AES-128");
   end

   aes_state_e fsm;
   aes_state_e fsm_next;
   aes_block_t state_reg;
   aes_block_t key_reg;
   aes_block_t next_key;
   aes_block_t round_out;
   logic [3:0] rnd;
   logic       last_round;

   assign last_round = (rnd == 4'(NUM_ROUNDS));
   assign next_key   = key_expand(key_reg, rcon(rnd));
   assign IN_READY   = (fsm == IDLE);
   assign OUT_VALID  = (fsm == DONE);

   aes_encryption_round u_round (
      .state       (state_reg),
      .round_key   (next_key),
      .final_round (last_round),
      .next_state  (round_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm <= IDLE;
      end else begin
         fsm <= fsm_next;
      end
   end

   always_comb begin
      fsm_next = fsm;
      case (fsm)
         IDLE:    if (IN_VALID) fsm_next = RUN;
         RUN:     if (last_round) fsm_next = DONE;
         DONE:    if (OUT_READY) fsm_next = IDLE;
         default: fsm_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= '0;
         key_reg   <= '0;
         rnd       <= '0;
         OUT_DATA  <= '0;
      end else begin
         case (fsm)
            IDLE: begin
               if (IN_VALID) begin
                  state_reg <= IN_DATA ^ IN_KEY;
                  key_reg   <= IN_KEY;
                  rnd       <= 4'd1;
               end
            end
            RUN: begin
               state_reg <= round_out;
               key_reg   <= next_key;
               rnd       <= rnd + 4'd1;
               if (last_round) OUT_DATA <= round_out;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encryption_core.sv
// Bench for aes_encryption_core: known-answer vectors, random blocks, backpressure,
// mid-run reset and back-to-back traffic against a byte-level AES reference model.
module tb_aes_encryption_core;

   typedef logic [43:0][31:0] sched_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         IN_VALID;
   logic         IN_READY;
   logic [127:0] IN_DATA;
   logic [127:0] IN_KEY;
   logic         OUT_VALID;
   logic         OUT_READY;
   logic [127:0] OUT_DATA;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_sbox [256];
   logic [7:0] m_inv  [256];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   always #5 clk = ~clk;

   aes_encryption_core #(.NUM_ROUNDS(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_DATA   (IN_DATA),
      .IN_KEY    (IN_KEY),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_DATA  (OUT_DATA)
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] av, inv, s;
      for (int a = 0; a < 256; a++) begin
         av  = a[7:0];
         inv = 8'h00;
         if (a != 0)
            for (int b = 1; b < 256; b++)
               if (gmul(av, b[7:0]) == 8'h01) inv = b[7:0];
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         m_sbox[a] = s;
         m_inv[s]  = av;
      end
   endtask

   function automatic sched_t expand(input logic [127:0] key);
      sched_t      w;
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      return w;
   endfunction

   function automatic logic [127:0] model_enc(input logic [127:0] key, input logic [127:0] pt);
      sched_t     w;
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] out;
      w = expand(key);
      for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) t[i] = m_sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
         if (rd < 10)
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31 - 8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
      return out;
   endfunction

   // Stands in for the downstream decryption chain in the round-trip check.
   function automatic logic [127:0] model_dec(input logic [127:0] key, input logic [127:0] ct);
      sched_t     w;
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] out;
      w = expand(key);
      for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ w[40 + i/4][31 - 8*(i%4) -: 8];
      for (int rd = 9; rd >= 0; rd--) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r + 4*((c + r) % 4)] = s[r + 4*c];
         for (int i = 0; i < 16; i++) s[i] = m_inv[t[i]] ^ w[4*rd + i/4][31 - 8*(i%4) -: 8];
         if (rd > 0)
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
               s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
               s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
               s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
      end
      for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
      return out;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus helpers ----------------
   // Waits (bounded) for IN_READY, presents one block, then counts edges after the
   // accepting edge until OUT_VALID is seen (lat = 40 means it never came).
   task automatic run_block(input logic [127:0] k, input logic [127:0] d, input logic rdy,
                            output logic [127:0] ct, output int lat);
      int n;
      n = 0;
      OUT_READY = rdy;
      IN_KEY    = k;
      IN_DATA   = d;
      IN_VALID  = 1'b1;
      while (!IN_READY && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      IN_VALID = 1'b0;
      IN_KEY   = rand128();
      IN_DATA  = rand128();
      lat = 0;
      while (!OUT_VALID && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      ct = OUT_DATA;
   endtask

   task automatic drain();
      OUT_READY = 1'b1;
      @(posedge clk); #1;
      OUT_READY = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; IN_DATA = '0; IN_KEY = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY); end
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
      checks++; if (OUT_DATA !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", OUT_DATA); end
   endtask

   // Latency 10 = OUT_VALID seen after the 10th edge following the accepting edge,
   // i.e. the 11th edge counting the accepting edge itself.
   task automatic test_kat(input string name, input logic [127:0] k, input logic [127:0] d,
                           input logic [127:0] exp);
      logic [127:0] ct;
      int lat;
      run_block(k, d, 1'b0, ct, lat);
      checks++; if (ct !== exp) begin errors++; $display("FAIL %s_ct: got %h expected %h", name, ct, exp); end
      checks++; if (ct !== model_enc(k, d)) begin errors++; $display("FAIL %s_model: got %h expected %h", name, ct, model_enc(k, d)); end
      checks++; if (lat != 10) begin errors++; $display("FAIL %s_latency: got %0d expected 10", name, lat); end
      drain();
      checks++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
         errors++; $display("FAIL %s_handshake: got ready=%b valid=%b expected ready=1 valid=0", name, IN_READY, OUT_VALID);
      end
      checks++; if (OUT_DATA !== exp) begin errors++; $display("FAIL %s_hold_after: got %h expected %h", name, OUT_DATA, exp); end
   endtask

   task automatic test_round_trip();
      logic [127:0] ct, pt;
      int lat;
      run_block(C1_KEY, C1_PT, 1'b0, ct, lat);
      drain();
      pt = model_dec(C1_KEY, ct);
      checks++; if (pt !== C1_PT) begin errors++; $display("FAIL round_trip: got %h expected %h", pt, C1_PT); end
   endtask

   task automatic test_backpressure();
      logic [127:0] k, d, exp, ct;
      int lat;
      k = rand128(); d = rand128(); exp = model_enc(k, d);
      run_block(k, d, 1'b0, ct, lat);
      checks++; if (ct !== exp) begin errors++; $display("FAIL bp_ct: got %h expected %h", ct, exp); end
      for (int i = 0; i < 20; i++) begin
         IN_VALID = 1'($urandom % 2);
         IN_DATA  = rand128();
         IN_KEY   = rand128();
         @(posedge clk); #1;
         checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, OUT_VALID); end
         checks++; if (OUT_DATA !== exp) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, OUT_DATA, exp); end
         checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, IN_READY); end
      end
      IN_VALID = 1'b0;
      drain();
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", IN_READY); end
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", OUT_VALID); end
      checks++; if (OUT_DATA !== exp) begin errors++; $display("FAIL bp_release_data: got %h expected %h", OUT_DATA, exp); end
      // OUT_READY while idle must not disturb anything.
      OUT_READY = 1'b1;
      repeat (3) @(posedge clk);
      #1 OUT_READY = 1'b0;
      checks++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || OUT_DATA !== exp) begin
         errors++; $display("FAIL idle_out_ready: got ready=%b valid=%b data=%h expected 1 0 %h", IN_READY, OUT_VALID, OUT_DATA, exp);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [127:0] ct;
      int lat;
      logic seen;
      OUT_READY = 1'b0;
      IN_KEY = C1_KEY; IN_DATA = C1_PT; IN_VALID = 1'b1;
      @(posedge clk); #1;
      IN_VALID = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", IN_READY); end
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", OUT_VALID); end
      checks++; if (OUT_DATA !== '0) begin errors++; $display("FAIL midrst_out_data: got %h expected 0", OUT_DATA); end
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (OUT_VALID) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_partial: got %b expected 0", seen); end
      run_block(C1_KEY, C1_PT, 1'b0, ct, lat);
      checks++; if (ct !== C1_CT) begin errors++; $display("FAIL midrst_fresh_ct: got %h expected %h", ct, C1_CT); end
      checks++; if (lat != 10) begin errors++; $display("FAIL midrst_fresh_latency: got %0d expected 10", lat); end
      drain();
   endtask

   task automatic test_random();
      logic [127:0] k, d, exp, ct;
      logic rdy;
      int lat;
      for (int i = 0; i < 20; i++) begin
         k = (i == 0) ? '1 : rand128();
         d = (i == 0) ? '1 : rand128();
         rdy = 1'($urandom % 2);
         exp = model_enc(k, d);
         run_block(k, d, rdy, ct, lat);
         checks++; if (ct !== exp) begin errors++; $display("FAIL rand_ct[%0d]: got %h expected %h", i, ct, exp); end
         checks++; if (lat != 10) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 10", i, lat); end
         if (!rdy) repeat ($urandom % 4) begin @(posedge clk); #1; end
         drain();
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] ka, da, kb, db;
      int acc [$];
      logic [127:0] outs [$];
      logic prev_ready;
      ka = rand128(); da = rand128(); kb = rand128(); db = rand128();
      OUT_READY = 1'b1;
      IN_KEY = ka; IN_DATA = da; IN_VALID = 1'b1;
      prev_ready = IN_READY;
      for (int t = 1; t <= 30; t++) begin
         @(posedge clk); #1;
         if (prev_ready && !IN_READY) begin
            acc.push_back(t);
            if (acc.size() == 1) begin IN_KEY = kb; IN_DATA = db; end
            else IN_VALID = 1'b0;
         end
         if (OUT_VALID) outs.push_back(OUT_DATA);
         prev_ready = IN_READY;
      end
      IN_VALID = 1'b0;
      OUT_READY = 1'b0;
      checks++; if (acc.size() != 2) begin errors++; $display("FAIL b2b_accepts: got %0d expected 2", acc.size()); end
      else begin
         checks++; if (acc[1] - acc[0] != 12) begin errors++; $display("FAIL b2b_period: got %0d expected 12", acc[1] - acc[0]); end
      end
      checks++; if (outs.size() != 2) begin errors++; $display("FAIL b2b_outputs: got %0d expected 2", outs.size()); end
      else begin
         checks++; if (outs[0] !== model_enc(ka, da)) begin errors++; $display("FAIL b2b_ct_a: got %h expected %h", outs[0], model_enc(ka, da)); end
         checks++; if (outs[1] !== model_enc(kb, db)) begin errors++; $display("FAIL b2b_ct_b: got %h expected %h", outs[1], model_enc(kb, db)); end
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_kat("c1", C1_KEY, C1_PT, C1_CT);
      test_kat("appb", 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32);
      test_kat("zero", '0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      test_round_trip();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time limit, expected completion");
      $fatal(1, "time limit");
   end

endmodule
